vz_ram_injector: RTL and testbench

//   Downstream stage of the VZ loader: turns its level-style vz_addr/vz_data/vz_wr stream into discrete RAM write strobes.

---
 rtl/vz_ram_injector.sv | 125 ++++++++++++
 tb/tb_vz_ram_injector.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vz_ram_injector.sv
// rtl/vz_ram_injector.sv - VZ loader write capture, RAM-window filter, FIFO and idle-slot RAM injector
module vz_ram_injector #(
   parameter int          DEPTH    = 16,
   parameter logic [15:0] RAM_BASE = 16'h7800,
   parameter logic [15:0] RAM_TOP  = 16'hFFFF
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic [15:0] vz_addr,
   input  logic [7:0]  vz_data,
   input  logic        vz_wr,
   input  logic        cpu_mreq,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        ram_we,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        overflow,
   output logic [15:0] wr_count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]  state;
   logic        prev_wr;
   logic [15:0] last_addr;
   logic [7:0]  last_data;
   logic [23:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   logic accept;
   logic in_win;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push;
   logic drop;
   logic start;

   // A level-high stream only yields a new write when the pair changes or vz_wr re-rises.
   assign accept     = vz_wr && (!prev_wr || (vz_addr != last_addr) || (vz_data != last_data));
   assign in_win     = ({1'b0, vz_addr} >= {1'b0, RAM_BASE}) && ({1'b0, vz_addr} <= {1'b0, RAM_TOP});
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !fifo_empty && !cpu_mreq;
   assign push       = accept && in_win && (!fifo_full || pop);
   assign drop       = accept && in_win && fifo_full && !pop;
   assign start      = (state == ST_IDLE) && vz_wr;

   assign cpu_hold  = (state != ST_IDLE);
   assign load_done = (state == ST_DONE);

   always_ff @(posedge I_CLK) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {vz_addr, vz_data};
      end
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         prev_wr   <= 1'b0;
         last_addr <= 16'h0000;
         last_data <= 8'h00;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_addr  <= 16'h0000;
         ram_dout  <= 8'h00;
         ram_we    <= 1'b0;
      end else begin
         prev_wr <= vz_wr;
         if (accept) begin
            last_addr <= vz_addr;
            last_data <= vz_data;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            ram_addr <= mem[rd_ptr[AW-1:0]][23:8];
            ram_dout <= mem[rd_ptr[AW-1:0]][7:0];
         end
         ram_we <= pop;
      end
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state    <= ST_IDLE;
         overflow <= 1'b0;
         wr_count <= 16'h0000;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end else if (start) begin
            overflow <= 1'b0;
         end
         if (start) begin
            wr_count <= 16'h0000;
         end else if (ram_we) begin
            wr_count <= wr_count + 16'd1;
         end
         // A rise seen during DONE is still high in IDLE, so IDLE starts on the level.
         case (state)
            ST_IDLE:  if (vz_wr) state <= ST_LOAD;
            ST_LOAD:  if (!vz_wr) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (vz_wr) begin
                  state <= ST_LOAD;
               end else if (fifo_empty && !ram_we) begin
                  state <= ST_DONE;
               end
            end
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vz_ram_injector.sv
// tb/tb_vz_ram_injector.sv - directed self-checking bench for vz_ram_injector
module tb_vz_ram_injector;

   logic        I_CLK = 1'b0;
   logic        I_RST = 1'b1;
   logic [15:0] vz_addr = 16'h0000;
   logic [7:0]  vz_data = 8'h00;
   logic        vz_wr = 1'b0;
   logic        cpu_mreq = 1'b0;
   logic [15:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic        cpu_hold;
   logic        load_done;
   logic        overflow;
   logic [15:0] wr_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_count = 0;
   int viol_count = 0;
   logic prev_mreq = 1'b0;
   logic [15:0] log_addr[$];
   logic [7:0]  log_data[$];
   int          log_cyc[$];

   vz_ram_injector dut (
      .I_CLK(I_CLK), .I_RST(I_RST), .vz_addr(vz_addr), .vz_data(vz_data), .vz_wr(vz_wr),
      .cpu_mreq(cpu_mreq), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we),
      .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow), .wr_count(wr_count)
   );

   always #5 I_CLK = ~I_CLK;

   always @(posedge I_CLK) cyc <= cyc + 1;

   // Outputs and inputs are both stable at the falling edge.
   always @(negedge I_CLK) begin
      if (ram_we) begin
         log_addr.push_back(ram_addr);
         log_data.push_back(ram_dout);
         log_cyc.push_back(cyc);
      end
      if (load_done) done_count++;
      if (ram_we && prev_mreq) viol_count++;
      prev_mreq = cpu_mreq;
   end

   task automatic tick();
      @(posedge I_CLK);
      #1;
   endtask

   task automatic wait_idle(input bit toggle, output bit timed_out);
      int n;
      n = 0;
      while (cpu_hold && n < 300) begin
         if (toggle) cpu_mreq = ~cpu_mreq;
         tick();
         n++;
      end
      cpu_mreq = 1'b0;
      timed_out = cpu_hold;
   endtask

   task automatic test_reset();
      I_RST = 1'b1;
      repeat (3) tick();
      checks++;
      if ({ram_addr, ram_dout, ram_we, cpu_hold, load_done, overflow, wr_count} !== 45'd0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%h dout=%h we=%b hold=%b done=%b ovf=%b cnt=%0d, required all 0",
                  ram_addr, ram_dout, ram_we, cpu_hold, load_done, overflow, wr_count);
      end
      I_RST = 1'b0;
      tick();
      checks++;
      if (cpu_hold !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: hold=%b we=%b, required 0 0", cpu_hold, ram_we);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ea[4];
      logic [7:0]  ed[4];
      int base, d0, c0;
      bit to;
      ea = '{16'h7AE9, 16'h7AEA, 16'h7AEB, 16'h7AEC};
      ed = '{8'h11, 8'h22, 8'h33, 8'h44};
      base = log_addr.size();
      d0 = done_count;
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         vz_wr = 1'b1; vz_addr = ea[i]; vz_data = ed[i];
         tick();
         if (i == 0) begin
            checks++;
            if (cpu_hold !== 1'b1) begin
               errors++;
               $display("FAIL basic_hold: cpu_hold=%b during load, required 1", cpu_hold);
            end
         end
      end
      vz_wr = 1'b0;
      wait_idle(1'b0, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: cpu_hold stuck 1, required 0"); end
      checks++;
      if (log_addr.size() - base != 4) begin
         errors++;
         $display("FAIL basic_count: %0d writes, required 4", log_addr.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== ea[i] || log_data[base+i] !== ed[i] || log_cyc[base+i] != c0 + 2 + i) begin
               errors++;
               $display("FAIL basic_write%0d: got %h/%h at cycle %0d, required %h/%h at cycle %0d",
                        i, log_addr[base+i], log_data[base+i], log_cyc[base+i], ea[i], ed[i], c0 + 2 + i);
            end
         end
      end
      checks++;
      if (wr_count !== 16'd4) begin errors++; $display("FAIL basic_wr_count: %0d, required 4", wr_count); end
      checks++;
      if (done_count - d0 != 1) begin
         errors++;
         $display("FAIL basic_load_done: %0d pulses, required 1", done_count - d0);
      end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: %b, required 0", overflow); end
   endtask

   task automatic test_repeat_pair();
      int base;
      bit to;
      base = log_addr.size();
      vz_wr = 1'b1; vz_addr = 16'h78A5; vz_data = 8'h12;
      repeat (10) tick();
      vz_wr = 1'b0;
      wait_idle(1'b0, to);
      checks++;
      if (to || log_addr.size() - base != 1 || log_addr[base] !== 16'h78A5 || log_data[base] !== 8'h12) begin
         errors++;
         $display("FAIL repeat_pair: %0d writes timeout=%b, required exactly one 78a5/12", log_addr.size() - base, to);
      end
      checks++;
      if (wr_count !== 16'd1) begin errors++; $display("FAIL repeat_wr_count: %0d, required 1", wr_count); end
   endtask

   task automatic test_window();
      int base;
      bit to;
      base = log_addr.size();
      for (int i = 0; i < 8; i++) begin
         vz_wr = 1'b1;
         vz_addr = i[0] ? 16'h8000 : 16'h4000;
         vz_data = 8'(i);
         tick();
      end
      vz_wr = 1'b0;
      wait_idle(1'b0, to);
      checks++;
      if (to || log_addr.size() - base != 4) begin
         errors++;
         $display("FAIL window_count: %0d writes timeout=%b, required 4", log_addr.size() - base, to);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== 16'h8000 || log_data[base+i] !== 8'(2*i+1)) begin
               errors++;
               $display("FAIL window_write%0d: got %h/%h, required 8000/%h", i, log_addr[base+i], log_data[base+i], 8'(2*i+1));
            end
         end
      end
      checks++;
      if (wr_count !== 16'd4) begin errors++; $display("FAIL window_wr_count: %0d, required 4", wr_count); end
   endtask

   task automatic test_overflow();
      int base, d0;
      bit to;
      base = log_addr.size();
      d0 = done_count;
      cpu_mreq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         vz_wr = 1'b1; vz_addr = 16'h9000 + 16'(i); vz_data = 8'(i + 1);
         tick();
      end
      vz_wr = 1'b0;
      repeat (3) tick();
      checks++;
      if (overflow !== 1'b1 || cpu_hold !== 1'b1 || log_addr.size() != base) begin
         errors++;
         $display("FAIL overflow_stalled: ovf=%b hold=%b writes=%0d, required 1 1 0",
                  overflow, cpu_hold, log_addr.size() - base);
      end
      cpu_mreq = 1'b0;
      wait_idle(1'b0, to);
      checks++;
      if (to || log_addr.size() - base != 16) begin
         errors++;
         $display("FAIL overflow_count: %0d writes timeout=%b, required 16", log_addr.size() - base, to);
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_addr[base+i] !== 16'h9000 + 16'(i) || log_data[base+i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL overflow_write%0d: got %h/%h, required %h/%h",
                        i, log_addr[base+i], log_data[base+i], 16'h9000 + 16'(i), 8'(i + 1));
            end
         end
      end
      checks++;
      if (wr_count !== 16'd16 || done_count - d0 != 1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_final: cnt=%0d done=%0d ovf=%b, required 16 1 1", wr_count, done_count - d0, overflow);
      end
   endtask

   task automatic test_mreq_toggle();
      int base, v0;
      bit to;
      base = log_addr.size();
      v0 = viol_count;
      for (int i = 0; i < 8; i++) begin
         cpu_mreq = ~i[0];
         vz_wr = 1'b1; vz_addr = 16'hA000 + 16'(i); vz_data = 8'h80 + 8'(i);
         tick();
      end
      vz_wr = 1'b0;
      wait_idle(1'b1, to);
      checks++;
      if (to || log_addr.size() - base != 8) begin
         errors++;
         $display("FAIL toggle_count: %0d writes timeout=%b, required 8", log_addr.size() - base, to);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_addr[base+i] !== 16'hA000 + 16'(i) || log_data[base+i] !== 8'h80 + 8'(i)) begin
               errors++;
               $display("FAIL toggle_write%0d: got %h/%h, required %h/%h",
                        i, log_addr[base+i], log_data[base+i], 16'hA000 + 16'(i), 8'h80 + 8'(i));
            end
         end
      end
      checks++;
      if (viol_count != v0 || wr_count !== 16'd8) begin
         errors++;
         $display("FAIL toggle_stall: %0d writes after cpu_mreq=1, cnt=%0d, required 0 and 8", viol_count - v0, wr_count);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      bit to;
      base = log_addr.size();
      cpu_mreq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 16) cpu_mreq = 1'b0;
         vz_wr = 1'b1; vz_addr = 16'hB000 + 16'(i); vz_data = 8'(8'h40 + i);
         tick();
      end
      vz_wr = 1'b0;
      wait_idle(1'b0, to);
      checks++;
      if (to || log_addr.size() - base != 20 || overflow !== 1'b0 || wr_count !== 16'd20) begin
         errors++;
         $display("FAIL full_push_pop: %0d writes ovf=%b cnt=%0d timeout=%b, required 20 0 20 0",
                  log_addr.size() - base, overflow, wr_count, to);
      end else begin
         for (int i = 0; i < 20; i++) begin
            checks++;
            if (log_addr[base+i] !== 16'hB000 + 16'(i) || log_data[base+i] !== 8'(8'h40 + i)) begin
               errors++;
               $display("FAIL full_push_pop_write%0d: got %h/%h, required %h/%h",
                        i, log_addr[base+i], log_data[base+i], 16'hB000 + 16'(i), 8'(8'h40 + i));
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int base, d0;
      for (int i = 0; i < 3; i++) begin
         vz_wr = 1'b1; vz_addr = 16'hC000 + 16'(i); vz_data = 8'(i);
         tick();
      end
      cpu_mreq = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vz_wr = 1'b1; vz_addr = 16'hC010 + 16'(i); vz_data = 8'(8'h50 + i);
         tick();
      end
      checks++;
      if (wr_count == 16'd0 || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL midload_setup: cnt=%0d hold=%b, required nonzero and 1", wr_count, cpu_hold);
      end
      #2;
      I_RST = 1'b1;
      #1;
      checks++;
      if ({ram_addr, ram_dout, ram_we, cpu_hold, load_done, overflow, wr_count} !== 45'd0) begin
         errors++;
         $display("FAIL midload_reset: got addr=%h dout=%h we=%b hold=%b done=%b ovf=%b cnt=%0d, required all 0",
                  ram_addr, ram_dout, ram_we, cpu_hold, load_done, overflow, wr_count);
      end
      vz_wr = 1'b0;
      cpu_mreq = 1'b0;
      tick();
      tick();
      base = log_addr.size();
      d0 = done_count;
      I_RST = 1'b0;
      repeat (20) tick();
      checks++;
      if (log_addr.size() != base || done_count != d0 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL midload_after: writes=%0d done=%0d hold=%b, required 0 0 0",
                  log_addr.size() - base, done_count - d0, cpu_hold);
      end
      test_basic();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat_pair();
      test_window();
      test_overflow();
      test_mreq_toggle();
      test_back_to_back();
      test_reset_mid_load();
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
